// File: rtl/scfifo_stream_reader.sv
// ---------------------------------------------------------------------------
// scfifo_stream_reader
//
// Read-side master for a single-clock FIFO whose read data is registered
// (data_out updates one cycle after rd_en && !empty). Pops the FIFO and
// presents the words on a valid/ready stream. Every PKT_LEN-th accepted beat
// is marked with m_last. Sustains one word per clock while the FIFO has data
// and the downstream is ready.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   en          permit issuing new FIFO reads (draining continues when low)
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO registered read data
//   fifo_rd_en  FIFO pop request (combinational)
//   m_valid     stream word valid
//   m_ready     downstream accept
//   m_data      stream word
//   m_last      last beat of packet
//   busy        a read is in flight or words are buffered
// ---------------------------------------------------------------------------
module scfifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int              CNT_W     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]      beat_q, beat_d;

  logic                  pop;
  logic [2:0]            pending;

  // Stream outputs come straight from the buffer head and occupancy.
  always_comb begin
    m_valid = (occ_q != 2'd0);
    m_data  = head_q;
    m_last  = m_valid && (beat_q == LAST_BEAT);
    busy    = inflight_q || (occ_q != 2'd0);
    pop     = m_valid && m_ready;
  end

  // Words that will occupy the buffer after this cycle's pop, counting the
  // read already in flight. Issuing only while this is below 2 guarantees
  // room for every word the FIFO returns. pop implies occ >= 1, so the
  // subtraction never wraps.
  always_comb begin
    pending    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = reset && en && !fifo_empty && (pending < 3'd2);
  end

  always_comb begin
    inflight_d = fifo_rd_en;
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    beat_d     = beat_q;

    case ({inflight_q, pop})
      2'b11: begin
        // Pop and capture together: occupancy unchanged, order preserved.
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = fifo_data;
        end else begin
          head_d = fifo_data;
        end
      end
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          head_d = fifo_data;
        end else begin
          tail_d = fifo_data;
        end
      end
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        head_d = tail_q;
      end
      default: ;
    endcase

    if (pop) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + CNT_W'(1);
    end
  end

  // State registers; reset discards any in-flight or buffered words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      beat_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
    end
  end

endmodule

// File: tb/tb_scfifo_stream_reader.sv
module tb_scfifo_stream_reader;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          en;
  logic          m_ready;
  logic          sel;  // 0: PKT_LEN=16 instance, 1: PKT_LEN=3 instance
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty;

  logic          rd16, v16, l16, b16;
  logic [DW-1:0] d16;
  logic          rd3, v3, l3, b3;
  logic [DW-1:0] d3;

  logic          fifo_rd_en, m_valid, m_last, busy;
  logic [DW-1:0] m_data;

  // FIFO model with registered read data
  logic [DW-1:0] mem [0:4095];
  int            wr_ptr = 0;
  int            rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_data <= mem[rd_ptr % 4096];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  scfifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(16)) dut16 (
    .clk        (clk),
    .reset      (reset),
    .en         (en && !sel),
    .fifo_empty (fifo_empty || sel),
    .fifo_data  (fifo_data),
    .fifo_rd_en (rd16),
    .m_valid    (v16),
    .m_ready    (m_ready),
    .m_data     (d16),
    .m_last     (l16),
    .busy       (b16)
  );

  scfifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(3)) dut3 (
    .clk        (clk),
    .reset      (reset),
    .en         (en && sel),
    .fifo_empty (fifo_empty || !sel),
    .fifo_data  (fifo_data),
    .fifo_rd_en (rd3),
    .m_valid    (v3),
    .m_ready    (m_ready),
    .m_data     (d3),
    .m_last     (l3),
    .busy       (b3)
  );

  assign fifo_rd_en = sel ? rd3 : rd16;
  assign m_valid    = sel ? v3  : v16;
  assign m_last     = sel ? l3  : l16;
  assign busy       = sel ? b3  : b16;
  assign m_data     = sel ? d3  : d16;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q [$];
  int            beat_m = 0;
  int            acc_cnt = 0;
  int            last_cnt = 0;
  int            cyc = 0;
  int            last_pop_cyc = 0;
  logic          pv = 1'b0, pp = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr % 4096] = v;
    wr_ptr++;
    exp_q.push_back(v);
  endtask

  // Scoreboard / stream-rule monitor, called once per cycle mid low phase.
  task automatic mon();
    logic          pop;
    logic [DW-1:0] ev;
    int            pkt;
    pkt = sel ? 3 : 16;
    pop = m_valid && m_ready;
    if (pv && !pp) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, pd);
      chk("hold_last", m_last, pl);
    end
    if (pop) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        chk("data", m_data, ev);
      end
      chk("last", m_last, beat_m == pkt - 1);
      if (m_last) last_cnt++;
      beat_m = (beat_m == pkt - 1) ? 0 : beat_m + 1;
      acc_cnt++;
      last_pop_cyc = cyc;
    end
    pv = m_valid;
    pp = pop;
    pd = m_data;
    pl = m_last;
    cyc++;
  endtask

  task automatic step();
    #1;
    mon();
    @(negedge clk);
  endtask

  task automatic run_all(input string tag, input int budget);
    int target;
    target = acc_cnt + exp_q.size();
    for (int i = 0; i < budget && acc_cnt < target; i++) step();
    chk(tag, acc_cnt, target);
  endtask

  initial begin
    int base, rdc, t0, n, pushed, keep;
    reset   = 1'b0;
    en      = 1'b0;
    m_ready = 1'b0;
    sel     = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Four words: issue cycles 0-3, data cycles 2-5, busy until 5
    for (int i = 1; i <= 4; i++) push(DW'(i));
    en      = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t1_rd_en", fifo_rd_en, (k < 4));
      chk("t1_valid", m_valid, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) chk("t1_data", m_data, k - 1);
      chk("t1_busy", busy, (k >= 1 && k <= 5));
      mon();
      @(negedge clk);
    end

    // Restart framing at beat 0
    reset  = 1'b0;
    pv     = 1'b0;
    beat_m = 0;
    step();
    reset = 1'b1;
    step();

    // 40-word continuous stream, lasts on beats 15 and 31
    last_cnt = 0;
    for (int i = 0; i < 40; i++) push(DW'(8'h20 + i));
    t0 = cyc;
    run_all("t2_done", 60);
    chk("t2_throughput", last_pop_cyc - t0, 41);
    chk("t2_lasts", last_cnt, 2);

    // Backpressure mid-stream
    for (int i = 0; i < 20; i++) push(DW'(8'h60 + i));
    for (int i = 0; i < 4; i++) step();
    m_ready = 1'b0;
    rdc = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (fifo_rd_en) rdc++;
      if (i == 4) begin
        chk("t3_rd_stall", fifo_rd_en, 0);
        chk("t3_valid", m_valid, 1);
        chk("t3_busy", busy, 1);
      end
      mon();
      @(negedge clk);
    end
    chk("t3_issues", rdc <= 1, 1);
    en      = 1'b0;
    m_ready = 1'b1;
    base    = acc_cnt;
    for (int i = 0; i < 4; i++) step();
    chk("t3_buffered_two", acc_cnt - base, 2);
    en = 1'b1;
    run_all("t3_done", 60);

    // en dropped right after an issue
    en = 1'b0;
    for (int i = 0; i < 6; i++) push(DW'(8'hA0 + i));
    step();
    en = 1'b1;
    #1;
    chk("t4_issue", fifo_rd_en, 1);
    mon();
    @(negedge clk);
    en   = 1'b0;
    base = acc_cnt;
    rdc  = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (fifo_rd_en) rdc++;
      mon();
      @(negedge clk);
    end
    chk("t4_no_issue", rdc, 0);
    chk("t4_one_word", acc_cnt - base, 1);
    #1;
    chk("t4_busy_low", busy, 0);
    @(negedge clk);
    en = 1'b1;
    run_all("t4_done", 40);

    // Switch to PKT_LEN=3 instance
    en     = 1'b0;
    sel    = 1'b1;
    beat_m = 0;
    pv     = 1'b0;
    step();
    en = 1'b1;

    // Random ready and refill, 1000 words
    last_cnt = 0;
    pushed   = 0;
    base     = acc_cnt;
    for (int i = 0; i < 20000 && acc_cnt < base + 1000; i++) begin
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 2);
        for (int j = 0; j < n && pushed < 1000; j++) begin
          push(DW'($urandom));
          pushed++;
        end
      end
      m_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    chk("t5_done", acc_cnt - base, 1000);
    chk("t5_lasts", last_cnt, 333);

    // Asynchronous reset with two words buffered
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(DW'(8'hC0 + i));
    for (int i = 0; i < 4; i++) step();
    #1;
    chk("t6_pre_valid", m_valid, 1);
    chk("t6_pre_busy", busy, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_valid", m_valid, 0);
    chk("t6_last", m_last, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rd_en", fifo_rd_en, 0);
    chk("t6_data", m_data, 0);
    pv     = 1'b0;
    beat_m = 0;
    keep   = wr_ptr - rd_ptr;
    while (exp_q.size() > keep) void'(exp_q.pop_front());
    @(negedge clk);
    step();
    reset    = 1'b1;
    m_ready  = 1'b1;
    last_cnt = 0;
    run_all("t6_done", 40);
    chk("t6_lasts", last_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scfifo_stream_reader.md
Name: scfifo_stream_reader

Overview:
- Read-side master for a single-clock FIFO with registered read data (FIFO `data_out` updates one cycle after `rd_en && !empty`).
- Pops the FIFO and presents the words on a valid/ready output stream.
- Marks every PKT_LEN-th beat with `m_last`.
- Sits between each channel FIFO and the downstream channel arbiter/serializer in the multichannel buffer.
- Sustains one word per clock while the FIFO is non-empty and the downstream is ready.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and stream data.
- PKT_LEN, 16, beats per packet; `m_last` marks beat PKT_LEN-1. Legal range is ≥1. Beat counter width is max(1, $clog2(PKT_LEN)).

Ports:
- clk  input  1  rising-edge clock, single domain.
- reset  input  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to clk by upstream.
- en  input  1  permit issuing new FIFO reads; does not block draining.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO registered read data.
- fifo_rd_en  output  1  FIFO pop request (combinational).
- m_valid  output  1  stream word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_WIDTH  stream word.
- m_last  output  1  last beat of packet.
- busy  output  1  `inflight || occ != 0`.

Behaviour:
- Internal state:
  - `inflight`: 1-bit register, FIFO read issued last cycle.
  - 2-entry ordered output buffer, with occupancy `occ` in 0..2.
  - `beat_cnt`.
- `pop = m_valid && m_ready`.
- `fifo_rd_en = reset && en && !fifo_empty && (occ + inflight - pop < 2)`.
  - Compute this with at least 3-bit arithmetic; no underflow is possible since `pop` implies `occ ≥ 1`.
  - Forced 0 while reset is low.
- `inflight <= fifo_rd_en` every cycle.
- When `inflight == 1`, `fifo_data` is captured into the buffer tail at the end of that cycle.
- Invariant: `occ + inflight ≤ 2` at all times. The buffer never overflows and no FIFO word is dropped.
- Simultaneous capture and pop in the same cycle:
  - Head is removed, new word appended, `occ` unchanged.
  - With `occ == 1`, the new word becomes the head.
  - With `occ == 2`, the second entry shifts to head and the new word takes the tail.
- Capture-only: `occ + 1`. Pop-only: `occ - 1`.
- Outputs:
  - `m_valid = (occ != 0)`.
  - `m_data` = buffer head.
  - `m_last = m_valid && (beat_cnt == PKT_LEN-1)`.
  - For PKT_LEN=1, `m_last = m_valid`.
- Stream rule: while `m_valid && !m_ready`, `m_data` and `m_last` hold stable. `m_valid` never deasserts without a pop.
- Beat counter: increments on pop; wraps to 0 on the pop where `beat_cnt == PKT_LEN-1`. Held otherwise.
- Latency: `fifo_rd_en` high in cycle T → word visible on `m_data` with `m_valid` in cycle T+2. Steady-state throughput is 1 word/cycle.
- Backpressure: `m_ready` low → at most one more issue, then issuing stops with `occ = 2`.
- `en` deasserted:
  - No new issue.
  - A pending `inflight` word is still captured.
  - The buffer drains normally.
  - `beat_cnt` is retained, so packet framing continues across en toggles.
- FIFO empty mid-stream: no issue; the output bubbles and `m_valid` drops after the buffer drains. Resumes when `fifo_empty` = 0.
- Reset values: `m_valid=0`, `m_last=0`, `m_data=0` (buffer cleared), `fifo_rd_en=0`, `busy=0`, `inflight=0`, `occ=0`, `beat_cnt=0`.
- Reset asserted mid-packet: any in-flight or buffered words are discarded. The FIFO has already popped them, and owning that data loss is the system's responsibility. Framing restarts at beat 0.

Test Plan:
- Reset, then FIFO loaded with 0x01..0x04, `en=1`, `m_ready=1` → `fifo_rd_en` high cycles 0-3. `m_data` 0x01..0x04 on consecutive cycles 2-5. `busy` drops after cycle 5.
- Continuous stream of 40 words, DATA_WIDTH=8, PKT_LEN=16, `m_ready=1` → 1 beat/cycle. `m_last` on beats 15, 31. `beat_cnt=8` at end, with no `m_last` on beat 39.
- `m_ready` held low 5 cycles mid-stream with FIFO non-empty → exactly 2 words buffered (`occ=2`), `fifo_rd_en` low. `m_data` stable. On release, words arrive in order with no loss or duplicate; scoreboard matches.
- `en` dropped in the same cycle as a read issue → that word still appears on the stream. No further `fifo_rd_en`. `busy` falls once drained. Re-enable resumes with a continuous beat count.
- Random `m_ready` (50%) and random FIFO refill, 1000 words, PKT_LEN=3 → in-order data. `m_last` every 3rd accepted beat. `m_valid` never drops without a pop.
- `reset` pulled low asynchronously (between edges) with `occ=2` → `m_valid`, `m_last`, `busy` and `fifo_rd_en` go 0 immediately. After release, the first accepted word has `beat_cnt` 0.
